// File: rtl/da_dct8_engine.sv
// Bit-serial distributed-arithmetic 8-point DCT engine: one coefficient per DATA_W cycles,
// either a single selected k or all k = 0..7 from one captured set of samples.
module da_dct8_engine #(
    parameter int unsigned DATA_W = 8,
    localparam int unsigned OUT_W = DATA_W + 19
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     start,
    input  logic                     all_k,
    input  logic [2:0]               k_sel,
    input  logic signed [DATA_W-1:0] x0,
    input  logic signed [DATA_W-1:0] x1,
    input  logic signed [DATA_W-1:0] x2,
    input  logic signed [DATA_W-1:0] x3,
    input  logic signed [DATA_W-1:0] x4,
    input  logic signed [DATA_W-1:0] x5,
    input  logic signed [DATA_W-1:0] x6,
    input  logic signed [DATA_W-1:0] x7,
    output logic                     busy,
    output logic                     out_valid,
    output logic [2:0]               out_k,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     done
);

    localparam int unsigned BW = $clog2(DATA_W);
    localparam logic [BW-1:0] BMSB = BW'(DATA_W - 1);

    localparam logic signed [15:0] A4 = 16'sd2896;
    localparam logic signed [15:0] A1 = 16'sd4017;
    localparam logic signed [15:0] A2 = 16'sd3784;
    localparam logic signed [15:0] A3 = 16'sd3406;
    localparam logic signed [15:0] A5 = 16'sd2276;
    localparam logic signed [15:0] A6 = 16'sd1567;
    localparam logic signed [15:0] A7 = 16'sd799;

    // Row k, column n: round(8192 * c(k) * cos((2n+1) k pi / 16)).
    localparam logic signed [15:0] COEF [8][8] = '{
        '{ A4,  A4,  A4,  A4,  A4,  A4,  A4,  A4},
        '{ A1,  A3,  A5,  A7, -A7, -A5, -A3, -A1},
        '{ A2,  A6, -A6, -A2, -A2, -A6,  A6,  A2},
        '{ A3, -A7, -A1, -A5,  A5,  A1,  A7, -A3},
        '{ A4, -A4, -A4,  A4,  A4, -A4, -A4,  A4},
        '{ A5, -A1,  A7,  A3, -A3, -A7,  A1, -A5},
        '{ A6, -A2,  A2, -A6, -A6,  A2, -A2,  A6},
        '{ A7, -A5,  A3, -A1,  A1, -A3,  A5, -A7}
    };

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e                    state_q;
    logic                      busy_q;
    logic                      valid_q;
    logic                      done_q;
    logic [2:0]                outk_q;
    logic signed [OUT_W-1:0]   outd_q;
    logic signed [OUT_W-1:0]   acc_q;
    logic [2:0]                k_q;
    logic [BW-1:0]             b_q;
    logic                      all_q;
    logic [DATA_W-1:0]         x_q [8];

    logic signed [18:0]        psum;
    logic signed [OUT_W-1:0]   psum_w;
    logic signed [OUT_W-1:0]   acc_d;

    // Partial sum of the coefficients whose sample has a 1 in the current bit plane.
    always_comb begin
        psum = '0;
        for (int n = 0; n < 8; n++) begin
            if (x_q[n][b_q]) begin
                psum = psum + 19'(COEF[k_q][n]);
            end
        end
        psum_w = OUT_W'(psum);
        // The MSB plane carries negative weight in two's complement.
        if (b_q == BMSB) begin
            acc_d = -psum_w;
        end else begin
            acc_d = {acc_q[OUT_W-2:0], 1'b0} + psum_w;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            outk_q  <= '0;
            outd_q  <= '0;
            acc_q   <= '0;
            k_q     <= '0;
            b_q     <= '0;
            all_q   <= 1'b0;
            for (int n = 0; n < 8; n++) begin
                x_q[n] <= '0;
            end
        end else if (en) begin
            unique case (state_q)
                StIdle: begin
                    // busy still high here means this is the final output-pulse cycle.
                    if (busy_q) begin
                        busy_q  <= 1'b0;
                        valid_q <= 1'b0;
                        done_q  <= 1'b0;
                    end else if (start) begin
                        x_q[0]  <= x0;
                        x_q[1]  <= x1;
                        x_q[2]  <= x2;
                        x_q[3]  <= x3;
                        x_q[4]  <= x4;
                        x_q[5]  <= x5;
                        x_q[6]  <= x6;
                        x_q[7]  <= x7;
                        all_q   <= all_k;
                        k_q     <= all_k ? 3'd0 : k_sel;
                        b_q     <= BMSB;
                        busy_q  <= 1'b1;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    valid_q <= 1'b0;
                    done_q  <= 1'b0;
                    acc_q   <= acc_d;
                    if (b_q == '0) begin
                        valid_q <= 1'b1;
                        outk_q  <= k_q;
                        outd_q  <= acc_d;
                        if (!all_q || k_q == 3'd7) begin
                            done_q  <= 1'b1;
                            state_q <= StIdle;
                        end else begin
                            k_q <= k_q + 3'd1;
                            b_q <= BMSB;
                        end
                    end else begin
                        b_q <= b_q - 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy      = busy_q;
    assign out_valid = valid_q;
    assign done      = done_q;
    assign out_k     = outk_q;
    assign out_data  = outd_q;

endmodule

// File: tb/tb_da_dct8_engine.sv
// Bench for da_dct8_engine: table vectors, random jobs against a floating-point DCT model,
// and hand-written sequences for restart, stall and mid-job reset.
module tb_da_dct8_engine;

    localparam int DW = 8;
    localparam int OW = DW + 19;
    localparam real PI = 3.14159265358979;

    logic                 clk = 1'b0;
    logic                 reset, en, start, all_k;
    logic [2:0]           k_sel;
    logic signed [DW-1:0] x [8];
    logic                 busy, out_valid, done;
    logic [2:0]           out_k;
    logic signed [OW-1:0] out_data;

    da_dct8_engine #(.DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .en(en), .start(start), .all_k(all_k), .k_sel(k_sel),
        .x0(x[0]), .x1(x[1]), .x2(x[2]), .x3(x[3]), .x4(x[4]), .x5(x[5]), .x6(x[6]), .x7(x[7]),
        .busy(busy), .out_valid(out_valid), .out_k(out_k), .out_data(out_data), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        int                   cyc;
        logic [2:0]           k;
        logic signed [OW-1:0] d;
        logic                 done;
    } ev_t;

    typedef struct packed {
        bit                   a;
        logic [2:0]           ks;
        logic [7:0][DW-1:0]   xp;
        logic [7:0][31:0]     ex;
    } vec_t;

    ev_t  got_q[$];
    ev_t  exp_q[$];
    ev_t  mon_e;
    bit   busy_hist [20000];
    int   nerr = 0;
    int   nchk = 0;

    always @(negedge clk) begin
        if (cyc < 20000) busy_hist[cyc] = (busy === 1'b1);
        if (out_valid === 1'b1 || done === 1'b1) begin
            mon_e.cyc  = cyc;
            mon_e.k    = out_k;
            mon_e.d    = out_data;
            mon_e.done = done;
            got_q.push_back(mon_e);
        end
    end

    function automatic int coef(int k, int n);
        real ck = (k == 0) ? $sqrt(0.125) : 0.5;
        real v  = 8192.0 * ck * $cos(real'((2 * n + 1) * k) * PI / 16.0);
        return (v >= 0.0) ? int'($floor(v + 0.5)) : -int'($floor(-v + 0.5));
    endfunction

    function automatic longint model(int k, logic [7:0][DW-1:0] xp);
        longint s = 0;
        for (int n = 0; n < 8; n++) s += longint'($signed(xp[n])) * longint'(coef(k, n));
        return s;
    endfunction

    function automatic logic [7:0][DW-1:0] mkx(int a0, int a1, int a2, int a3,
                                               int a4, int a5, int a6, int a7);
        logic [7:0][DW-1:0] r;
        r[0] = DW'(a0); r[1] = DW'(a1); r[2] = DW'(a2); r[3] = DW'(a3);
        r[4] = DW'(a4); r[5] = DW'(a5); r[6] = DW'(a6); r[7] = DW'(a7);
        return r;
    endfunction

    function automatic logic [7:0][DW-1:0] rndx();
        logic [7:0][DW-1:0] r;
        for (int n = 0; n < 8; n++) r[n] = DW'($urandom);
        return r;
    endfunction

    task automatic chk(input string name, input logic signed [63:0] g,
                       input logic signed [63:0] e);
        nchk++;
        if (g !== e) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, g, e);
        end
    endtask

    task automatic set_x(input logic [7:0][DW-1:0] xp);
        for (int n = 0; n < 8; n++) x[n] = xp[n];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input bit a, input logic [2:0] ks, input logic [7:0][DW-1:0] xp,
                             output int t);
        step();
        all_k = a;
        k_sel = ks;
        set_x(xp);
        start = 1'b1;
        t = cyc;
        step();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 2000; i++) begin
            if (busy === 1'b0 && out_valid === 1'b0) break;
            step();
        end
        chk({name, " idle"}, busy, 0);
        step();
        step();
    endtask

    task automatic add_expected(input int t, input bit a, input logic [2:0] ks,
                                input logic [7:0][DW-1:0] xp, input int shift);
        ev_t e;
        if (a) begin
            for (int i = 0; i < 8; i++) begin
                e.cyc  = t + DW * (i + 1) + 1 + shift;
                e.k    = 3'(i);
                e.d    = OW'(model(i, xp));
                e.done = (i == 7);
                exp_q.push_back(e);
            end
        end else begin
            e.cyc  = t + DW + 1 + shift;
            e.k    = ks;
            e.d    = OW'(model(int'(ks), xp));
            e.done = 1'b1;
            exp_q.push_back(e);
        end
    endtask

    task automatic compare_events(input string name);
        chk({name, " count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            nchk++;
            if (got_q[i] !== exp_q[i]) begin
                nerr++;
                $display("FAIL %s ev%0d: got cyc=%0d k=%0d d=%0d done=%0b expected cyc=%0d k=%0d d=%0d done=%0b",
                         name, i, got_q[i].cyc, got_q[i].k, got_q[i].d, got_q[i].done,
                         exp_q[i].cyc, exp_q[i].k, exp_q[i].d, exp_q[i].done);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: no finish after %0d cycles", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t               tbl [5];
        int                 t;
        bit                 a;
        logic [2:0]         ks;
        logic [7:0][DW-1:0] xa, xb;
        ev_t                e;

        tbl[0] = '0; tbl[0].ks = 3'd0; tbl[0].xp = mkx(10, 10, 10, 10, 10, 10, 10, 10);
        tbl[0].ex[0] = 32'(231680);
        tbl[1] = '0; tbl[1].ks = 3'd4; tbl[1].xp = mkx(5, -5, -5, 5, 5, -5, -5, 5);
        tbl[1].ex[0] = 32'(115840);
        tbl[2] = '0; tbl[2].ks = 3'd0; tbl[2].xp = mkx(5, -5, -5, 5, 5, -5, -5, 5);
        tbl[2].ex[0] = 32'(0);
        tbl[3] = '0; tbl[3].ks = 3'd0;
        tbl[3].xp = mkx(-128, -128, -128, -128, -128, -128, -128, -128);
        tbl[3].ex[0] = 32'(-2965504);
        tbl[4] = '0; tbl[4].a = 1'b1; tbl[4].xp = mkx(1, 0, 0, 0, 0, 0, 0, 0);
        tbl[4].ex[0] = 32'(2896); tbl[4].ex[1] = 32'(4017); tbl[4].ex[2] = 32'(3784);
        tbl[4].ex[3] = 32'(3406); tbl[4].ex[4] = 32'(2896); tbl[4].ex[5] = 32'(2276);
        tbl[4].ex[6] = 32'(1567); tbl[4].ex[7] = 32'(799);

        reset = 1'b1; en = 1'b1; start = 1'b0; all_k = 1'b0; k_sel = 3'd0;
        set_x('0);
        repeat (3) step();
        reset = 1'b0;
        chk("reset busy", busy, 0);
        chk("reset out_valid", out_valid, 0);
        chk("reset done", done, 0);
        chk("reset out_k", out_k, 0);
        chk("reset out_data", out_data, 0);
        got_q.delete();

        for (int i = 0; i < 5; i++) begin
            start_job(tbl[i].a, tbl[i].ks, tbl[i].xp, t);
            wait_idle("table");
            if (i == 0) begin
                chk("busy before accept", busy_hist[t], 0);
                chk("busy after accept", busy_hist[t + 1], 1);
                chk("busy on out_valid", busy_hist[t + DW + 1], 1);
                chk("busy after done", busy_hist[t + DW + 2], 0);
            end
            for (int j = 0; j < got_q.size() && j < 8; j++) begin
                chk($sformatf("table%0d data%0d", i, j), got_q[j].d,
                    $signed(tbl[i].ex[tbl[i].a ? j : 0]));
            end
            add_expected(t, tbl[i].a, tbl[i].ks, tbl[i].xp, 0);
            compare_events($sformatf("table%0d", i));
        end

        for (int i = 0; i < 24; i++) begin
            a  = ($urandom_range(3) == 0);
            ks = 3'($urandom);
            xa = rndx();
            start_job(a, ks, xa, t);
            wait_idle("random");
            add_expected(t, a, ks, xa, 0);
            compare_events($sformatf("random%0d", i));
        end

        // start held through the job with changed inputs; only the cycle after done accepts.
        xa = rndx();
        xb = rndx();
        start_job(1'b0, 3'd2, xa, t);
        add_expected(t, 1'b0, 3'd2, xa, 0);
        set_x(xb);
        k_sel = 3'd5;
        all_k = 1'b1;
        step();
        start = 1'b1;
        all_k = 1'b0;
        while (cyc < t + DW + 2) step();
        step();
        start = 1'b0;
        add_expected(t + DW + 2, 1'b0, 3'd5, xb, 0);
        wait_idle("restart");
        chk("restart busy gap", busy_hist[t + DW + 2], 0);
        compare_events("restart");

        // en low for 3 cycles inside the first coefficient of an all_k job.
        xa = rndx();
        start_job(1'b1, 3'($urandom), xa, t);
        step();
        step();
        en = 1'b0;
        repeat (3) step();
        en = 1'b1;
        wait_idle("stall run");
        add_expected(t, 1'b1, 3'd0, xa, 3);
        compare_events("stall run");

        // en low during the output pulse stretches it.
        xa = rndx();
        start_job(1'b0, 3'd3, xa, t);
        while (cyc < t + DW + 1) step();
        en = 1'b0;
        repeat (2) step();
        en = 1'b1;
        wait_idle("stall pulse");
        for (int s = 0; s < 3; s++) begin
            e.cyc  = t + DW + 1 + s;
            e.k    = 3'd3;
            e.d    = OW'(model(3, xa));
            e.done = 1'b1;
            exp_q.push_back(e);
        end
        compare_events("stall pulse");

        // start is not sampled while en is low.
        step();
        en = 1'b0;
        start = 1'b1;
        repeat (3) step();
        start = 1'b0;
        en = 1'b1;
        repeat (2) step();
        chk("en-low start busy", busy, 0);
        compare_events("en-low start");

        // Reset after the first coefficient of an all_k job.
        xa = rndx();
        start_job(1'b1, 3'd0, xa, t);
        while (cyc < t + 12) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midreset busy", busy, 0);
        chk("midreset out_valid", out_valid, 0);
        chk("midreset done", done, 0);
        chk("midreset out_k", out_k, 0);
        chk("midreset out_data", out_data, 0);
        repeat (80) step();
        e.cyc  = t + DW + 1;
        e.k    = 3'd0;
        e.d    = OW'(model(0, xa));
        e.done = 1'b0;
        exp_q.push_back(e);
        compare_events("midreset");

        xa = rndx();
        start_job(1'b0, 3'd6, xa, t);
        wait_idle("after reset");
        add_expected(t, 1'b0, 3'd6, xa, 0);
        compare_events("after reset");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
